adc_bcd_converter: RTL and testbench



---
 rtl/adc_bcd_converter.sv | 134 +++++++++++++
 tb/tb_adc_bcd_converter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adc_bcd_converter.sv
// rtl/adc_bcd_converter.sv - block-averages ADC samples and converts the mean to four BCD digits
module adc_bcd_converter #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic [3:0]        ones,
    output logic [3:0]        tens,
    output logic [3:0]        hundreds,
    output logic [3:0]        thousands,
    output logic              bcd_valid,
    output logic              busy,
    output logic              avg_overrun
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SH_W  = 16 + DATA_W;
    localparam int IT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              dv_q;
    logic              accept;
    logic              last_sample;
    logic              avg_ready;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] avg;
    logic [SH_W-1:0]   sh;
    logic [SH_W-1:0]   sh_adj;
    logic [IT_W-1:0]   iter;
    logic              start_conv;
    logic              conv_step;
    logic              load_digits;

    // A level held high on data_valid counts as a single sample.
    assign accept      = data_valid & ~dv_q;
    assign last_sample = (cnt == CNT_LAST);
    assign acc_sum     = acc + ACC_W'(data_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_ready <= 1'b0;
        end else begin
            dv_q      <= data_valid;
            avg_ready <= 1'b0;
            if (accept) begin
                if (last_sample) begin
                    avg       <= DATA_W'(acc_sum >> AVG_LOG2);
                    acc       <= '0;
                    cnt       <= '0;
                    avg_ready <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (avg_ready) state_next = CONV;
            CONV:    if (iter == IT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        start_conv  = (state == IDLE) && avg_ready;
        conv_step   = (state == CONV);
        load_digits = (state == DONE);
    end

    // Add-3 correction on every BCD nibble before each shift.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < 4; i++) begin
            if (sh[DATA_W + 4*i +: 4] >= 4'd5)
                sh_adj[DATA_W + 4*i +: 4] = sh[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh          <= '0;
            iter        <= '0;
            ones        <= 4'd0;
            tens        <= 4'd0;
            hundreds    <= 4'd0;
            thousands   <= 4'd0;
            bcd_valid   <= 1'b0;
            avg_overrun <= 1'b0;
        end else begin
            bcd_valid   <= load_digits;
            avg_overrun <= avg_ready && busy;
            if (start_conv) begin
                sh   <= {16'b0, avg};
                iter <= '0;
            end else if (conv_step) begin
                sh   <= {sh_adj[SH_W-2:0], 1'b0};
                iter <= iter + IT_W'(1);
            end
            if (load_digits) begin
                thousands <= sh[SH_W-1  -: 4];
                hundreds  <= sh[SH_W-5  -: 4];
                tens      <= sh[SH_W-9  -: 4];
                ones      <= sh[SH_W-13 -: 4];
            end
        end
    end

endmodule

// File: tb/tb_adc_bcd_converter.sv
// tb/tb_adc_bcd_converter.sv - scoreboard bench for adc_bcd_converter at AVG_LOG2=0 and 2
module tb_adc_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] din_a = '0, din_b = '0;
    logic        dv_a = 1'b0, dv_b = 1'b0;
    logic [3:0]  ones_a, tens_a, hundreds_a, thousands_a;
    logic [3:0]  ones_b, tens_b, hundreds_b, thousands_b;
    logic        bcd_valid_a, busy_a, ovr_a;
    logic        bcd_valid_b, busy_b, ovr_b;

    typedef struct {
        int digits;
        int cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    int   busy_cnt_a = 0, ovr_cnt_a = 0, ovr_cyc_a = 0, ovr_cnt_b = 0, bcd_cnt_b = 0;
    int   base;

    adc_bcd_converter #(.DATA_W(12), .AVG_LOG2(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(din_a), .data_valid(dv_a),
        .ones(ones_a), .tens(tens_a), .hundreds(hundreds_a), .thousands(thousands_a),
        .bcd_valid(bcd_valid_a), .busy(busy_a), .avg_overrun(ovr_a)
    );

    adc_bcd_converter #(.DATA_W(12), .AVG_LOG2(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(din_b), .data_valid(dv_b),
        .ones(ones_b), .tens(tens_b), .hundreds(hundreds_b), .thousands(thousands_b),
        .bcd_valid(bcd_valid_b), .busy(busy_b), .avg_overrun(ovr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    // One-cycle pulse; expv < 0 means no conversion result is expected from it.
    task automatic send(input bit to_b, input int v, input int expv);
        exp_t e;
        @(negedge clk);
        if (to_b) begin din_b = 12'(v); dv_b = 1'b1; end
        else      begin din_a = 12'(v); dv_a = 1'b1; end
        if (expv >= 0) begin
            e.digits = to_bcd(expv);
            e.cyc    = cyc + 15;
            if (to_b) q_b.push_back(e);
            else      q_a.push_back(e);
        end
        @(negedge clk);
        if (to_b) dv_b = 1'b0;
        else      dv_a = 1'b0;
    endtask

    task automatic wait_drain(input bit to_b);
        for (int i = 0; i < 60 && (to_b ? q_b.size() : q_a.size()) != 0; i++)
            @(negedge clk);
        check(to_b ? "drain_b" : "drain_a", to_b ? q_b.size() : q_a.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy_a) busy_cnt_a++;
            if (ovr_a) begin ovr_cnt_a++; ovr_cyc_a = cyc; end
            if (ovr_b) ovr_cnt_b++;
            if (bcd_valid_a) begin
                if (q_a.size() == 0) check("spurious_a", 1, 0);
                else begin
                    e_a = q_a.pop_front();
                    check("digits_a", {thousands_a, hundreds_a, tens_a, ones_a}, e_a.digits);
                    check("latency_a", cyc, e_a.cyc);
                end
            end
            if (bcd_valid_b) begin
                bcd_cnt_b++;
                if (q_b.size() == 0) check("spurious_b", 1, 0);
                else begin
                    e_b = q_b.pop_front();
                    check("digits_b", {thousands_b, hundreds_b, tens_b, ones_b}, e_b.digits);
                    check("latency_b", cyc, e_b.cyc);
                end
            end
        end
    end

    initial begin
        repeat (6) begin
            @(negedge clk);
            din_a = 12'($urandom); dv_a = 1'($urandom);
            din_b = 12'($urandom); dv_b = 1'($urandom);
        end
        check("rst_digits_a", {thousands_a, hundreds_a, tens_a, ones_a}, 0);
        check("rst_flags_a", {bcd_valid_a, busy_a, ovr_a}, 0);
        check("rst_digits_b", {thousands_b, hundreds_b, tens_b, ones_b}, 0);
        check("rst_flags_b", {bcd_valid_b, busy_b, ovr_b}, 0);
        dv_a = 1'b0; dv_b = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        busy_cnt_a = 0;
        send(0, 4095, 4095);
        wait_drain(0);
        check("busy_cycles_a", busy_cnt_a, 13);

        send(1, 100, -1);
        send(1, 200, -1);
        send(1, 300, -1);
        repeat (20) @(negedge clk);
        check("no_early_b", bcd_cnt_b, 0);
        send(1, 401, 250);
        wait_drain(1);

        @(negedge clk);
        din_b = 12'd7; dv_b = 1'b1;
        repeat (6) @(negedge clk);
        dv_b = 1'b0;
        send(1, 7, -1);
        send(1, 7, -1);
        send(1, 7, 7);
        wait_drain(1);
        check("count_b", bcd_cnt_b, 2);

        send(0, 1234, 1234);
        base = cyc;
        repeat (2) @(negedge clk);
        send(0, 999, -1);
        wait_drain(0);
        repeat (4) @(negedge clk);
        check("ovr_count_a", ovr_cnt_a, 1);
        check("ovr_cycle_a", ovr_cyc_a, base + 5);
        check("hold_a", {thousands_a, hundreds_a, tens_a, ones_a}, 'h1234);

        send(1, 1000, -1);
        send(1, 1000, -1);
        send(0, 500, -1);
        repeat (4) @(negedge clk);
        check("busy_before_rst", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check("busy_async_clr", busy_a, 0);
        check("digits_rst_clr", {thousands_a, hundreds_a, tens_a, ones_a}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        send(1, 8, -1);
        send(1, 8, -1);
        send(1, 8, -1);
        send(1, 12, 9);
        wait_drain(1);

        for (int v = 0; v < 4096; v++) begin
            send(0, v, v);
            wait_drain(0);
        end

        repeat (4) @(negedge clk);
        check("ovr_total_a", ovr_cnt_a, 1);
        check("ovr_total_b", ovr_cnt_b, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
